// File: rtl/joe_pkg.sv
// Shared types and constants for the joe sprite.
// Also used by the hit-box checkers and the colour mapper.
package joe_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HIT  = 2'd2,
    DOWN = 2'd3
  } joe_state_t;

  localparam logic [1:0] HIT_NONE = 2'b00;
  localparam logic [1:0] HIT_FALL = 2'b01;
  localparam logic [1:0] HIT_DOWN = 2'b10;

  localparam logic [7:0] KEY_SPACE = 8'h2C;

  localparam int JOE_HALF_W = 42;
  localparam int JOE_HALF_H = 46;

endpackage

// File: rtl/frame_tick_gen.sv
// Brings vsync into the Clk domain and emits a
// one-cycle tick on its rising edge.
module frame_tick_gen (
  input  logic Clk,
  input  logic Reset_n,
  input  logic frame_clk,
  output logic tick
);

  logic r_s1;
  logic r_s2;
  logic r_s3;

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= frame_clk;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign tick = r_s2 & ~r_s3;

endmodule

// File: rtl/joe_motion.sv
// Per-frame motion and hit state for the joe sprite:
// thrust, gravity, edge clamp and obstacle hits.
module joe_motion
  import joe_pkg::*;
#(
  parameter int X_START    = 120,
  parameter int Y_START    = 240,
  parameter int Y_MIN      = 46,
  parameter int Y_MAX      = 433,
  parameter int GRAVITY    = 1,
  parameter int THRUST     = 2,
  parameter int VMAX       = 8,
  parameter int HIT_FRAMES = 60
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       frame_clk,
  input  logic [7:0] keycode,
  input  logic       game_run,
  input  logic       collide,
  output logic [9:0] centerx,
  output logic [9:0] centery,
  output logic [5:0] vel_y,
  output logic [1:0] hit_joe,
  output logic       joe_dead
);

  localparam logic signed [6:0]  L_NTHR  = 7'(-THRUST);
  localparam logic signed [6:0]  L_GRAV  = 7'(GRAVITY);
  localparam logic signed [6:0]  L_VMAX  = 7'(VMAX);
  localparam logic signed [6:0]  L_NVMAX = 7'(-VMAX);
  localparam logic signed [10:0] L_YMIN  = 11'(Y_MIN);
  localparam logic signed [10:0] L_YMAX  = 11'(Y_MAX);
  localparam logic [9:0]         L_YMIN10 = 10'(Y_MIN);
  localparam logic [9:0]         L_YMAX10 = 10'(Y_MAX);
  localparam logic [9:0]         L_YST10  = 10'(Y_START);
  localparam logic [7:0]         L_HLAST  = 8'(HIT_FRAMES - 1);

  joe_state_t         r_state;
  logic [9:0]         r_cy;
  logic signed [5:0]  r_vel;
  logic [7:0]         r_timer;
  logic               r_col;

  logic               w_tick;
  logic               w_col;
  logic               w_thrust;
  logic signed [6:0]  w_vsum;
  logic signed [5:0]  w_vnext;
  logic signed [10:0] w_ynext;
  logic [9:0]         w_yclamp;
  logic signed [5:0]  w_vclamp;

  frame_tick_gen u_tick (
    .Clk      (Clk),
    .Reset_n  (Reset_n),
    .frame_clk(frame_clk),
    .tick     (w_tick)
  );

  // A collide on the tick cycle itself still counts
  assign w_col    = r_col | collide;
  assign w_thrust = (keycode == KEY_SPACE) && (r_state == RUN);
  assign w_vsum   = {r_vel[5], r_vel}
                  + (w_thrust ? L_NTHR : L_GRAV);

  always_comb begin
    w_vnext = w_vsum[5:0];
    if (w_vsum > L_VMAX)
      w_vnext = L_VMAX[5:0];
    else if (w_vsum < L_NVMAX)
      w_vnext = L_NVMAX[5:0];
  end

  assign w_ynext = {1'b0, r_cy}
                 + {{5{w_vnext[5]}}, w_vnext};

  always_comb begin
    w_yclamp = w_ynext[9:0];
    w_vclamp = w_vnext;
    if (w_ynext < L_YMIN) begin
      w_yclamp = L_YMIN10;
      w_vclamp = '0;
    end else if (w_ynext > L_YMAX) begin
      w_yclamp = L_YMAX10;
      w_vclamp = '0;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      r_state <= IDLE;
      r_cy    <= L_YST10;
      r_vel   <= '0;
      r_timer <= '0;
      r_col   <= 1'b0;
    end else begin
      r_col <= w_tick ? 1'b0 : (r_col | collide);
      if (w_tick) begin
        unique case (r_state)
          IDLE: begin
            r_cy  <= L_YST10;
            r_vel <= '0;
            if (game_run)
              r_state <= RUN;
          end
          RUN: begin
            if (!game_run) begin
              r_state <= IDLE;
              r_cy    <= L_YST10;
              r_vel   <= '0;
            end else if (w_col) begin
              r_state <= HIT;
              r_timer <= '0;
              r_vel   <= '0;
            end else begin
              r_cy  <= w_yclamp;
              r_vel <= w_vclamp;
            end
          end
          HIT: begin
            if (!game_run) begin
              r_state <= IDLE;
              r_cy    <= L_YST10;
              r_vel   <= '0;
            end else if (r_timer == L_HLAST
                || w_yclamp == L_YMAX10) begin
              r_state <= DOWN;
              r_cy    <= L_YMAX10;
              r_vel   <= '0;
            end else begin
              r_timer <= r_timer + 8'd1;
              r_cy    <= w_yclamp;
              r_vel   <= w_vclamp;
            end
          end
          DOWN: begin
            r_cy  <= L_YMAX10;
            r_vel <= '0;
            if (!game_run) begin
              r_state <= IDLE;
              r_cy    <= L_YST10;
            end
          end
        endcase
      end
    end
  end

  always_comb begin
    hit_joe = HIT_NONE;
    case (r_state)
      HIT:     hit_joe = HIT_FALL;
      DOWN:    hit_joe = HIT_DOWN;
      default: hit_joe = HIT_NONE;
    endcase
  end

  assign centerx  = 10'(X_START);
  assign centery  = r_cy;
  assign vel_y    = r_vel;
  assign joe_dead = (r_state == DOWN);

endmodule

// File: tb/tb_joe_motion.sv
// Randomised bench for joe_motion; two instances
// (default and short hit window) against a frame-level model.
module tb_joe_motion;

  logic       Clk;
  logic       Reset_n;
  logic       frame_clk;
  logic [7:0] keycode;
  logic       game_run;
  logic       collide;

  logic [9:0]  cx [2];
  logic [9:0]  cy [2];
  logic [5:0]  vy [2];
  logic [1:0]  hj [2];
  logic        jd [2];
  logic [28:0] obs [2];

  int checks = 0;
  int errors = 0;

  localparam int S_IDLE = 0;
  localparam int S_RUN  = 1;
  localparam int S_HIT  = 2;
  localparam int S_DOWN = 3;

  int m_st [2];
  int m_y  [2];
  int m_v  [2];
  int m_t  [2];
  int hf   [2] = '{60, 3};

  joe_motion u_dut0 (
    .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk),
    .keycode(keycode), .game_run(game_run), .collide(collide),
    .centerx(cx[0]), .centery(cy[0]), .vel_y(vy[0]),
    .hit_joe(hj[0]), .joe_dead(jd[0])
  );

  joe_motion #(.HIT_FRAMES(3)) u_dut1 (
    .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk),
    .keycode(keycode), .game_run(game_run), .collide(collide),
    .centerx(cx[1]), .centery(cy[1]), .vel_y(vy[1]),
    .hit_joe(hj[1]), .joe_dead(jd[1])
  );

  assign obs[0] = {cx[0], cy[0], vy[0], hj[0], jd[0]};
  assign obs[1] = {cx[1], cy[1], vy[1], hj[1], jd[1]};

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic logic [28:0] exp_vec(input int d);
    logic [1:0] h;
    h = (m_st[d] == S_HIT)  ? 2'b01 :
        (m_st[d] == S_DOWN) ? 2'b10 : 2'b00;
    return {10'd120, 10'(m_y[d]), 6'(m_v[d]), h,
            1'(m_st[d] == S_DOWN)};
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_st[d] = S_IDLE; m_y[d] = 240; m_v[d] = 0; m_t[d] = 0;
    end
  endtask

  task automatic to_idle(input int d);
    m_st[d] = S_IDLE; m_y[d] = 240; m_v[d] = 0;
  endtask

  // One frame of the game rules, at frame granularity
  task automatic model_tick(input logic [7:0] key,
                            input bit run, input bit col);
    int nv, ny;
    for (int d = 0; d < 2; d++) begin
      case (m_st[d])
        S_IDLE: if (run) m_st[d] = S_RUN;
        S_RUN: begin
          if (!run) to_idle(d);
          else if (col) begin
            m_st[d] = S_HIT; m_t[d] = 0; m_v[d] = 0;
          end else begin
            nv = m_v[d] + ((key == 8'h2C) ? -2 : 1);
            if (nv > 8) nv = 8;
            if (nv < -8) nv = -8;
            ny = m_y[d] + nv;
            if (ny < 46) begin m_y[d] = 46; m_v[d] = 0; end
            else if (ny > 433) begin m_y[d] = 433; m_v[d] = 0; end
            else begin m_y[d] = ny; m_v[d] = nv; end
          end
        end
        S_HIT: begin
          if (!run) to_idle(d);
          else begin
            nv = (m_v[d] + 1 > 8) ? 8 : m_v[d] + 1;
            ny = m_y[d] + nv;
            if (m_t[d] == hf[d] - 1 || ny >= 433) begin
              m_st[d] = S_DOWN; m_y[d] = 433; m_v[d] = 0;
            end else begin
              m_t[d] = m_t[d] + 1; m_y[d] = ny; m_v[d] = nv;
            end
          end
        end
        default: begin
          m_y[d] = 433; m_v[d] = 0;
          if (!run) to_idle(d);
        end
      endcase
    end
  endtask

  task automatic run_frame(input logic [7:0] key,
                           input bit run, input bit col);
    @(negedge Clk);
    keycode  = key;
    game_run = run;
    if (col) begin
      collide = 1'b1;
      @(negedge Clk);
      collide = 1'b0;
    end
    @(negedge Clk);
    frame_clk = 1'b1;
    repeat (3) @(posedge Clk);
    #1;
    model_tick(key, run, col);
    @(negedge Clk);
    frame_clk = 1'b0;
    repeat (2) @(negedge Clk);
  endtask

  task automatic test_reset();
    Reset_n = 1'b0; frame_clk = 1'b0; keycode = 8'h00;
    game_run = 1'b0; collide = 1'b0;
    model_reset();
    repeat (2) @(posedge Clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (obs[d] !== exp_vec(d)) begin
        errors++;
        $display("FAIL reset dut%0d: got %h want %h",
                 d, obs[d], exp_vec(d));
      end
    end
    @(negedge Clk);
    Reset_n = 1'b1;
    for (int f = 0; f < 3; f++) begin
      run_frame(8'h00, 1'b0, 1'b0);
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (obs[d] !== exp_vec(d)) begin
          errors++;
          $display("FAIL idle_hold f%0d dut%0d: got %h want %h",
                   f, d, obs[d], exp_vec(d));
        end
      end
    end
  endtask

  task automatic test_gravity();
    for (int f = 0; f < 10; f++) begin
      run_frame(8'h00, 1'b1, 1'b0);
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (obs[d] !== exp_vec(d)) begin
          errors++;
          $display("FAIL gravity f%0d dut%0d: y=%0d v=%0d got %h want %h",
                   f, d, cy[d], $signed(vy[d]), obs[d], exp_vec(d));
        end
      end
    end
  endtask

  task automatic test_thrust();
    for (int f = 0; f < 40; f++) begin
      run_frame(8'h2C, 1'b1, 1'b0);
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (obs[d] !== exp_vec(d)) begin
          errors++;
          $display("FAIL thrust f%0d dut%0d: y=%0d v=%0d got %h want %h",
                   f, d, cy[d], $signed(vy[d]), obs[d], exp_vec(d));
        end
      end
    end
    checks++;
    if (cy[0] !== 10'd46 || vy[0] !== 6'd0) begin
      errors++;
      $display("FAIL top_clamp: got y=%0d v=%0d want y=46 v=0",
               cy[0], $signed(vy[0]));
    end
  endtask

  task automatic test_collide();
    int f;
    run_frame(8'h2C, 1'b1, 1'b1);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (obs[d] !== exp_vec(d)) begin
        errors++;
        $display("FAIL hit_entry dut%0d: got %h want %h",
                 d, obs[d], exp_vec(d));
      end
    end
    f = 0;
    while (hj[0] !== 2'b10 && f < 100) begin
      run_frame(8'h2C, 1'b1, (f % 4) == 1);
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (obs[d] !== exp_vec(d)) begin
          errors++;
          $display("FAIL hit_fall f%0d dut%0d: y=%0d got %h want %h",
                   f, d, cy[d], obs[d], exp_vec(d));
        end
      end
      f++;
    end
    checks++;
    if (hj[0] !== 2'b10 || jd[0] !== 1'b1 || cy[0] !== 10'd433) begin
      errors++;
      $display("FAIL down_reached: got hit=%b dead=%b y=%0d want 10 1 433",
               hj[0], jd[0], cy[0]);
    end
    run_frame(8'h00, 1'b1, 1'b0);
    run_frame(8'h00, 1'b0, 1'b0);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (obs[d] !== exp_vec(d) || cy[d] !== 10'd240) begin
        errors++;
        $display("FAIL down_to_idle dut%0d: got %h want %h",
                 d, obs[d], exp_vec(d));
      end
    end
  endtask

  task automatic test_latency();
    run_frame(8'h00, 1'b1, 1'b0);
    run_frame(8'h00, 1'b1, 1'b0);
    @(negedge Clk);
    frame_clk = 1'b1;
    repeat (2) @(posedge Clk);
    #1;
    checks++;
    if (obs[0] !== exp_vec(0)) begin
      errors++;
      $display("FAIL latency_early: got %h want %h", obs[0], exp_vec(0));
    end
    @(posedge Clk);
    #1;
    model_tick(8'h00, 1'b1, 1'b0);
    checks++;
    if (obs[0] !== exp_vec(0)) begin
      errors++;
      $display("FAIL latency_edge3: got %h want %h", obs[0], exp_vec(0));
    end
    @(negedge Clk);
    frame_clk = 1'b0;
    repeat (2) @(negedge Clk);
  endtask

  task automatic test_reset_midframe();
    run_frame(8'h00, 1'b1, 1'b0);
    run_frame(8'h00, 1'b1, 1'b0);
    @(negedge Clk);
    frame_clk = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    Reset_n  = 1'b0;
    game_run = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    model_reset();
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (obs[d] !== exp_vec(d)) begin
        errors++;
        $display("FAIL reset_mid dut%0d: got %h want %h",
                 d, obs[d], exp_vec(d));
      end
    end
    @(negedge Clk);
    Reset_n = 1'b1;
    repeat (6) @(posedge Clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (obs[d] !== exp_vec(d)) begin
        errors++;
        $display("FAIL reset_release dut%0d: got %h want %h",
                 d, obs[d], exp_vec(d));
      end
    end
    @(negedge Clk);
    frame_clk = 1'b0;
    repeat (2) @(negedge Clk);
  endtask

  task automatic test_random();
    logic [7:0] key;
    bit run, col;
    for (int f = 0; f < 120; f++) begin
      key = ($urandom_range(0, 1) == 1) ? 8'h2C
            : 8'($urandom_range(0, 255));
      run = ($urandom_range(0, 9) != 0);
      col = ($urandom_range(0, 9) == 0);
      run_frame(key, run, col);
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (obs[d] !== exp_vec(d)) begin
          errors++;
          $display("FAIL random f%0d dut%0d: got %h want %h",
                   f, d, obs[d], exp_vec(d));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_gravity();
    test_thrust();
    test_collide();
    test_latency();
    test_reset_midframe();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
